// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall, multi-cycle execute stall, flushes.
// Optional stall performance counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_unit #(
    parameter int unsigned MC_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        LoadE,
    input  logic        PCSrcE,
    input  logic        MulStartE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        FlushD,
    output logic        FlushE,
    output logic        BusyE,
    output logic        MulDoneE,
    output logic [15:0] StallCount
);

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned PERF_W  = 16;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LATENCY - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             lw_stall;
    logic             mc_stall;

    // Forwarding: Memory stage result wins over Writeback; x0 never forwards.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;
    end

    assign lw_stall = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (MulStartE) begin
                    state_nx = BUSY;
                    cnt_nx   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt != '0) cnt_nx = cnt - CNT_W'(1);
                else           state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // The start cycle plus MC_LATENCY-1 busy cycles stall; the done cycle releases the pipe.
    always_comb begin
        BusyE    = 1'b0;
        MulDoneE = 1'b0;
        mc_stall = 1'b0;
        case (state)
            IDLE: mc_stall = MulStartE;
            BUSY: begin
                BusyE    = 1'b1;
                MulDoneE = (cnt == '0);
                mc_stall = (cnt != '0);
            end
            default: ;
        endcase
    end

    assign StallF = lw_stall | mc_stall;
    assign StallD = lw_stall | mc_stall;
    assign StallE = mc_stall;
    assign FlushE = (lw_stall | PCSrcE) & ~mc_stall;
    assign FlushD = PCSrcE & ~mc_stall;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count_q <= '0;
        else if (StallF && (stall_count_q != {PERF_W{1'b1}}))
            stall_count_q <= stall_count_q + PERF_W'(1);
    end

    assign StallCount = stall_count_q;
`else
    assign StallCount = PERF_W'(0);
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (MC_LATENCY=4); counter checks need HAZARD_PERF_CNT_EN.
module tb_hazard_unit;

    logic        clk;
    logic        rst_n;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        RegWriteM, RegWriteW, LoadE, PCSrcE, MulStartE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, FlushD, FlushE, BusyE, MulDoneE;
    logic [15:0] StallCount;

    int total = 0;
    int bad   = 0;

    hazard_unit #(.MC_LATENCY(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .LoadE(LoadE), .PCSrcE(PCSrcE), .MulStartE(MulStartE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE),
        .BusyE(BusyE), .MulDoneE(MulDoneE), .StallCount(StallCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
        RdE = '0; RdM = '0; RdW = '0;
        RegWriteM = 1'b0; RegWriteW = 1'b0;
        LoadE = 1'b0; PCSrcE = 1'b0; MulStartE = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #2;
        check("rst_busy", 16'(BusyE), 16'd0);
        check("rst_done", 16'(MulDoneE), 16'd0);
        check("rst_stall_e", 16'(StallE), 16'd0);
        check("rst_count", StallCount, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // Forwarding priority and x0 exclusion
        RegWriteM = 1'b1; RdM = 5'd5; RegWriteW = 1'b1; RdW = 5'd5; Rs1E = 5'd5; #1;
        check("fwd_a_mem", 16'(ForwardAE), 16'd2);
        RegWriteM = 1'b0; #1;
        check("fwd_a_wb", 16'(ForwardAE), 16'd1);
        RdW = 5'd0; #1;
        check("fwd_a_none", 16'(ForwardAE), 16'd0);
        clear_inputs();
        Rs2E = 5'd9; RdM = 5'd9; RegWriteM = 1'b1; RdW = 5'd9; RegWriteW = 1'b1; Rs1E = 5'd3; #1;
        check("fwd_b_mem", 16'(ForwardBE), 16'd2);
        check("fwd_a_nomatch", 16'(ForwardAE), 16'd0);
        RdM = 5'd4; #1;
        check("fwd_b_wb", 16'(ForwardBE), 16'd1);
        RegWriteW = 1'b0; #1;
        check("fwd_b_nowe", 16'(ForwardBE), 16'd0);
        RdM = 5'd0; Rs2E = 5'd0; RegWriteM = 1'b1; #1;
        check("fwd_b_x0", 16'(ForwardBE), 16'd0);
        clear_inputs(); #1;

        // Load-use stall
        LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7; #1;
        check("lu_stall_f", 16'(StallF), 16'd1);
        check("lu_stall_d", 16'(StallD), 16'd1);
        check("lu_flush_e", 16'(FlushE), 16'd1);
        check("lu_stall_e", 16'(StallE), 16'd0);
        check("lu_flush_d", 16'(FlushD), 16'd0);
        Rs2D = 5'd0; Rs1D = 5'd7; #1;
        check("lu_rs1_stall", 16'(StallF), 16'd1);
        RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0; #1;
        check("lu_x0_stall_f", 16'(StallF), 16'd0);
        check("lu_x0_stall_d", 16'(StallD), 16'd0);
        check("lu_x0_flush_e", 16'(FlushE), 16'd0);
        LoadE = 1'b0; RdE = 5'd7; Rs2D = 5'd7; #1;
        check("lu_noload", 16'(StallF), 16'd0);
        clear_inputs(); #1;

        // Branch flush in IDLE
        PCSrcE = 1'b1; #1;
        check("br_flush_d", 16'(FlushD), 16'd1);
        check("br_flush_e", 16'(FlushE), 16'd1);
        check("br_stall_f", 16'(StallF), 16'd0);
        PCSrcE = 1'b0;

        // Multi-cycle op: 4 stall cycles, busy cycles 2..5, done in cycle 5
        next_cycle();
        MulStartE = 1'b1; #1;
        for (int i = 1; i <= 5; i++) begin
            check($sformatf("mc_stall_e_c%0d", i), 16'(StallE), 16'(i <= 4));
            check($sformatf("mc_stall_f_c%0d", i), 16'(StallF), 16'(i <= 4));
            check($sformatf("mc_busy_c%0d", i), 16'(BusyE), 16'(i >= 2));
            check($sformatf("mc_done_c%0d", i), 16'(MulDoneE), 16'(i == 5));
            if (i < 5) next_cycle();
        end

        // Back-to-back: MulStartE still high right after done starts a new op
        next_cycle();
        check("b2b_start_stall", 16'(StallE), 16'd1);
        check("b2b_start_busy", 16'(BusyE), 16'd0);
        check("b2b_start_done", 16'(MulDoneE), 16'd0);
        next_cycle();
        check("b2b_busy", 16'(BusyE), 16'd1);
        next_cycle();
        // cnt==2 now: branch must not kill the running op
        PCSrcE = 1'b1; #1;
        check("mask_flush_d", 16'(FlushD), 16'd0);
        check("mask_flush_e", 16'(FlushE), 16'd0);
        check("mask_stall_e", 16'(StallE), 16'd1);

        // Asynchronous reset mid-op
        PCSrcE = 1'b0; MulStartE = 1'b0;
        rst_n = 1'b0; #1;
        check("arst_busy", 16'(BusyE), 16'd0);
        check("arst_stall_e", 16'(StallE), 16'd0);
        check("arst_done", 16'(MulDoneE), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            check($sformatf("post_rst_busy_%0d", i), 16'(BusyE), 16'd0);
            check($sformatf("post_rst_stall_%0d", i), 16'(StallE), 16'd0);
        end

`ifdef HAZARD_PERF_CNT_EN
        rst_n = 1'b0; #1;
        check("perf_rst", StallCount, 16'd0);
        rst_n = 1'b1;
        next_cycle();
        LoadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
        repeat (3) next_cycle();
        clear_inputs();
        MulStartE = 1'b1;
        repeat (5) next_cycle();
        MulStartE = 1'b0; #1;
        check("perf_count7", StallCount, 16'd7);
        LoadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
        repeat (65530) next_cycle();
        check("perf_sat", StallCount, 16'hFFFF);
        next_cycle();
        check("perf_sat_hold", StallCount, 16'hFFFF);
        clear_inputs();
`else
        check("perf_tied_zero", StallCount, 16'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
